piso_mux_serializer: RTL
========================

Name: piso_mux_serializer

Overview:
- Upstream sequencing stage for mux_4to1: accepts a 4-bit parallel word over a valid/ready handshake.
- Latches the word and walks the mux select through all four positions, producing a serial bitstream with a qualifying valid strobe.
- Converts the hand-driven select sequence used in mux bring-up into a self-timed, clocked serializer.

Parameters:
- BIT_PERIOD, 1, clock cycles each bit is held on ser_out; legal range 1..16, elaboration error otherwise.
- MSB_FIRST, 0, 0 = send in[0] first (sel 00→11); 1 = send in[3] first (sel 11→00).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  4  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word (high only in IDLE).
- ser_out  output  1  current serial bit = data_q[sel_q].
- ser_valid  output  1  ser_out is a valid payload bit.
- sel_out  output  2  current mux select, for debug/probing.
- last_bit  output  1  high during the final cycle of the final bit of a word.
- busy  output  1  high while in SEND.

Behaviour:
- One clock and one reset: rst is asynchronous and active-high; clk is the single clock.
- Reset values: state=IDLE, data_q=0, sel_q=0, period counter=0, in_ready=1, ser_valid=0, ser_out=0, sel_out=0, last_bit=0, busy=0.
- States are IDLE and SEND.
- IDLE:
  - in_ready=1; ser_valid=0; ser_out forced to 0.
  - On a clk edge with in_valid=1: data_q<=in_data; sel_q<=(MSB_FIRST ? 3 : 0); cnt<=0; go to SEND.
- SEND:
  - in_ready=0; in_valid is ignored and no word is queued.
  - ser_valid=1; busy=1; ser_out = data_q[sel_q], via the mux_4to1 instance.
  - Each clk: if cnt==BIT_PERIOD-1, then cnt<=0 and sel_q steps (+1, or -1 when MSB_FIRST), else cnt<=cnt+1.
  - last_bit=1 when sel_q is the final index (3, or 0 when MSB_FIRST) and cnt==BIT_PERIOD-1.
  - On the edge where last_bit=1: go to IDLE; sel_q returns to its reset value.
- Latency:
  - First bit appears the cycle after acceptance.
  - A word occupies 4*BIT_PERIOD SEND cycles.
  - in_ready reasserts the cycle after last_bit, so throughput is one word per 4*BIT_PERIOD+1 cycles.
- Width rules:
  - cnt width is max(1, clog2(BIT_PERIOD)).
  - sel_q is 2 bits and never wraps past the final index within a word.
- ser_out, sel_out, last_bit and busy are driven combinationally from registered state only (no input-to-output paths).
- Boundary cases:
  - in_valid held high continuously: a new word is accepted on each IDLE cycle; words are separated by one idle gap.
  - in_data changing during SEND has no effect; the latched data_q is sent.
  - rst asserted mid-word: outputs go to reset values immediately (asynchronously); the partial word is discarded, with no resume.
  - rst deasserted: IDLE with in_ready=1; a word is accepted on the first edge with in_valid=1.
  - BIT_PERIOD=1: cnt stays 0, sel_q steps every cycle.

Decomposition:
- Shared package holds:
  - localparams ST_IDLE=1'b0 and ST_SEND=1'b1;
  - SEL_FIRST_LSB=2'b00 and SEL_FIRST_MSB=2'b11;
  - the BIT_PERIOD legal-range constants.
- One sub-module is natural: instantiate the existing mux_4to1 (ports in[3:0], sel[1:0], out) for ser_out selection.
- The counter and FSM stay in this module.

Test Plan:
- Reset check: rst=1 mid-simulation → in_ready=1, ser_valid=0, ser_out=0, sel_out=00 immediately, before the next clk edge.
- LSB-first serialization: BIT_PERIOD=1, MSB_FIRST=0, in_data=4'b1010 with one in_valid pulse.
  - Next 4 cycles: sel_out=00,01,10,11 and ser_out=0,1,0,1; ser_valid=1.
  - last_bit=1 on the 4th cycle; in_ready=1 on the 5th.
- MSB-first with bit stretching: BIT_PERIOD=3, MSB_FIRST=1, in_data=4'b0110.
  - ser_out = 0,0,0,1,1,1,1,1,1,0,0,0 over 12 cycles.
  - sel_out = 11 ×3, 10 ×3, 01 ×3, 00 ×3; last_bit only on cycle 12.
- Back-to-back words: in_valid held high with in_data=4'b1111 then 4'b0001.
  - Both words are sent intact, with exactly one ser_valid=0 gap between them.
  - Changes to in_data during SEND are ignored.
- Abort: assert rst during the 2nd bit of 4'b1010.
  - ser_valid drops immediately.
  - After release, a new word 4'b0101 is sent as 1,0,1,0 (LSB first) with no remnant of the aborted word.

Source files
------------

// File: rtl/piso_mux_serializer_pkg.sv
// Shared constants for the 4-bit parallel-in / serial-out sequencer.
package piso_mux_serializer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [1:0] SEL_FIRST_LSB = 2'b00;
  localparam logic [1:0] SEL_FIRST_MSB = 2'b11;

  localparam int BIT_PERIOD_MIN = 1;
  localparam int BIT_PERIOD_MAX = 16;

endpackage

// File: rtl/piso_mux_serializer_mux_4to1.sv
// Plain 4:1 bit multiplexer, reused from mux bring-up to pick the serial bit.
module mux_4to1 (
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out
);

  assign out = in[sel];

endmodule

// File: rtl/piso_mux_serializer.sv
// Latches a 4-bit word over valid/ready and walks the mux select through all
// four positions, holding each bit for BIT_PERIOD cycles.
module piso_mux_serializer
  import piso_mux_serializer_pkg::*;
#(
  parameter int BIT_PERIOD = 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_out,
  output logic       ser_valid,
  output logic [1:0] sel_out,
  output logic       last_bit,
  output logic       busy
);

  if (BIT_PERIOD < BIT_PERIOD_MIN || BIT_PERIOD > BIT_PERIOD_MAX) begin : g_bad_bit_period
    $error("piso_mux_serializer: BIT_PERIOD=%0d outside 1..16", BIT_PERIOD);
  end

  localparam int              CNT_W     = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [1:0]      SEL_START = MSB_FIRST ? SEL_FIRST_MSB : SEL_FIRST_LSB;
  localparam logic [1:0]      SEL_LAST  = MSB_FIRST ? SEL_FIRST_LSB : SEL_FIRST_MSB;

  logic [0:0]       state_reg, state_next;
  logic [3:0]       data_reg, data_next;
  logic [1:0]       sel_reg, sel_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic sending;
  logic bit_done;
  logic mux_bit;

  assign sending  = (state_reg == ST_SEND);
  assign bit_done = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = ST_SEND;
          data_next  = in_data;
          sel_next   = SEL_START;
          cnt_next   = '0;
        end
      end
      default: begin
        if (bit_done) begin
          cnt_next = '0;
          if (sel_reg == SEL_LAST) begin
            // Park the select at zero so idle probing matches the reset view.
            state_next = ST_IDLE;
            sel_next   = 2'b00;
          end else if (MSB_FIRST) begin
            sel_next = sel_reg - 2'd1;
          end else begin
            sel_next = sel_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      data_reg  <= '0;
      sel_reg   <= 2'b00;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
    end
  end

  mux_4to1 u_mux (
    .in  (data_reg),
    .sel (sel_reg),
    .out (mux_bit)
  );

  // All outputs derive from registered state only; no input feeds through.
  assign in_ready  = ~sending;
  assign busy      = sending;
  assign ser_valid = sending;
  assign ser_out   = sending & mux_bit;
  assign sel_out   = sel_reg;
  assign last_bit  = sending & bit_done & (sel_reg == SEL_LAST);

endmodule
